// File: rtl/apple1_kbd_pkg.sv
// Shared scan codes, receiver state encoding and the PS/2 set-2 to Apple-1 ASCII table.
// The F1/F12 hotkey codes are only acted on when APPLE1_KBD_HOTKEYS_EN is defined.
package apple1_kbd_pkg;

    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_ESC    = 8'h76;
    localparam logic [7:0] SC_F1     = 8'h05;
    localparam logic [7:0] SC_F12    = 8'h07;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

    // Returns 7'h00 for codes with no printable mapping; letters are uppercase either way.
    function automatic logic [6:0] ps2_to_ascii(input logic [7:0] code, input logic shift);
        logic [6:0] base;
        logic [6:0] shifted;
        base    = 7'h00;
        shifted = 7'h00;
        case (code)
            8'h1C: {base, shifted} = {7'h41, 7'h41};
            8'h32: {base, shifted} = {7'h42, 7'h42};
            8'h21: {base, shifted} = {7'h43, 7'h43};
            8'h23: {base, shifted} = {7'h44, 7'h44};
            8'h24: {base, shifted} = {7'h45, 7'h45};
            8'h2B: {base, shifted} = {7'h46, 7'h46};
            8'h34: {base, shifted} = {7'h47, 7'h47};
            8'h33: {base, shifted} = {7'h48, 7'h48};
            8'h43: {base, shifted} = {7'h49, 7'h49};
            8'h3B: {base, shifted} = {7'h4A, 7'h4A};
            8'h42: {base, shifted} = {7'h4B, 7'h4B};
            8'h4B: {base, shifted} = {7'h4C, 7'h4C};
            8'h3A: {base, shifted} = {7'h4D, 7'h4D};
            8'h31: {base, shifted} = {7'h4E, 7'h4E};
            8'h44: {base, shifted} = {7'h4F, 7'h4F};
            8'h4D: {base, shifted} = {7'h50, 7'h50};
            8'h15: {base, shifted} = {7'h51, 7'h51};
            8'h2D: {base, shifted} = {7'h52, 7'h52};
            8'h1B: {base, shifted} = {7'h53, 7'h53};
            8'h2C: {base, shifted} = {7'h54, 7'h54};
            8'h3C: {base, shifted} = {7'h55, 7'h55};
            8'h2A: {base, shifted} = {7'h56, 7'h56};
            8'h1D: {base, shifted} = {7'h57, 7'h57};
            8'h22: {base, shifted} = {7'h58, 7'h58};
            8'h35: {base, shifted} = {7'h59, 7'h59};
            8'h1A: {base, shifted} = {7'h5A, 7'h5A};
            8'h16: {base, shifted} = {7'h31, 7'h21};
            8'h1E: {base, shifted} = {7'h32, 7'h40};
            8'h26: {base, shifted} = {7'h33, 7'h23};
            8'h25: {base, shifted} = {7'h34, 7'h24};
            8'h2E: {base, shifted} = {7'h35, 7'h25};
            8'h36: {base, shifted} = {7'h36, 7'h5E};
            8'h3D: {base, shifted} = {7'h37, 7'h26};
            8'h3E: {base, shifted} = {7'h38, 7'h2A};
            8'h46: {base, shifted} = {7'h39, 7'h28};
            8'h45: {base, shifted} = {7'h30, 7'h29};
            8'h29: {base, shifted} = {7'h20, 7'h20};
            8'h4E: {base, shifted} = {7'h2D, 7'h5F};
            8'h55: {base, shifted} = {7'h3D, 7'h2B};
            8'h54: {base, shifted} = {7'h5B, 7'h7B};
            8'h5B: {base, shifted} = {7'h5D, 7'h7D};
            8'h5D: {base, shifted} = {7'h5C, 7'h7C};
            8'h4C: {base, shifted} = {7'h3B, 7'h3A};
            8'h52: {base, shifted} = {7'h27, 7'h22};
            8'h41: {base, shifted} = {7'h2C, 7'h3C};
            8'h49: {base, shifted} = {7'h2E, 7'h3E};
            8'h4A: {base, shifted} = {7'h2F, 7'h3F};
            8'h0E: {base, shifted} = {7'h60, 7'h7E};
            SC_ENTER: {base, shifted} = {7'h0D, 7'h0D};
            SC_BKSP:  {base, shifted} = {7'h5F, 7'h5F};
            SC_ESC:   {base, shifted} = {7'h1B, 7'h1B};
            default:  {base, shifted} = {7'h00, 7'h00};
        endcase
        return shift ? shifted : base;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: input synchronizers, clock glitch filter, 11-bit frame FSM and
// inter-edge timeout. Emits a registered code_valid / frame_err pulse per frame.
module ps2_rx_frame
    import apple1_kbd_pkg::*;
#(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 28636
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_din,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TOW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FCW-1:0] FILT_MAX = FCW'(FILTER_LEN - 1);
    localparam logic [TOW-1:0] TO_MAX   = TOW'(TIMEOUT_CYC);

    logic [1:0]     clk_sync_reg;
    logic [1:0]     din_sync_reg;
    logic           clk_filt_reg;
    logic [FCW-1:0] filt_cnt_reg;
    logic [TOW-1:0] to_cnt_reg;
    logic           clk_s;
    logic           din_s;
    logic           filt_done;
    logic           fall;

    rx_state_t  state_reg, state_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] data_reg, data_next;
    logic       parity_reg, parity_next;
    logic       valid_reg, valid_next;
    logic       err_reg, err_next;

    assign clk_s     = clk_sync_reg[1];
    assign din_s     = din_sync_reg[1];
    assign filt_done = (clk_s != clk_filt_reg) && (filt_cnt_reg == FILT_MAX);
    assign fall      = filt_done && clk_filt_reg;

    // Synchronizers and filter reset to the idle-high bus level so release never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_reg <= 2'b11;
            din_sync_reg <= 2'b11;
            clk_filt_reg <= 1'b1;
            filt_cnt_reg <= '0;
            to_cnt_reg   <= '0;
        end else begin
            clk_sync_reg <= {clk_sync_reg[0], ps2_clk};
            din_sync_reg <= {din_sync_reg[0], ps2_din};
            if (clk_s == clk_filt_reg) begin
                filt_cnt_reg <= '0;
            end else if (filt_done) begin
                clk_filt_reg <= clk_s;
                filt_cnt_reg <= '0;
            end else begin
                filt_cnt_reg <= filt_cnt_reg + FCW'(1);
            end
            if (fall)
                to_cnt_reg <= '0;
            else if (to_cnt_reg != TO_MAX)
                to_cnt_reg <= to_cnt_reg + TOW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            data_reg    <= '0;
            parity_reg  <= 1'b0;
            valid_reg   <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            data_reg    <= data_next;
            parity_reg  <= parity_next;
            valid_reg   <= valid_next;
            err_reg     <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        data_next    = data_reg;
        parity_next  = parity_reg;
        valid_next   = 1'b0;
        err_next     = 1'b0;
        if (fall) begin
            case (state_reg)
                IDLE: begin
                    if (!din_s) begin
                        state_next   = DATA;
                        bit_cnt_next = '0;
                    end
                end
                DATA: begin
                    data_next    = {din_s, data_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7)
                        state_next = PARITY;
                end
                PARITY: begin
                    parity_next = din_s;
                    state_next  = STOP;
                end
                STOP: begin
                    state_next = IDLE;
                    if (din_s && (^{data_reg, parity_reg}))
                        valid_next = 1'b1;
                    else
                        err_next = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end else if (state_reg != IDLE && to_cnt_reg == TO_MAX) begin
            state_next = IDLE;
            data_next  = '0;
            err_next   = 1'b1;
        end
    end

    assign code       = data_reg;
    assign code_valid = valid_reg;
    assign frame_err  = err_reg;

endmodule

// File: rtl/apple1_ps2_kbd.sv
// Apple-1 PIA keyboard front-end: decodes PS/2 set-2 codes into KBD/KBDCR values.
// Define APPLE1_KBD_HOTKEYS_EN to enable the F12 reset and F1 clear-screen hotkeys.
module apple1_ps2_kbd
    import apple1_kbd_pkg::*;
#(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 28636
) (
    input  logic       clk14,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_din,
    input  logic       kbd_rd,
    output logic [7:0] key_data,
    output logic       key_ready,
    output logic       frame_err,
    output logic       reset_key,
    output logic       cls_key
);

    logic [7:0] code;
    logic       code_valid;
    logic [6:0] ascii_raw;
    logic [6:0] ascii;
    logic       new_key;

    logic brk_reg, brk_next;
    logic ext_reg, ext_next;
    logic shift_reg, shift_next;
    logic ctrl_reg, ctrl_next;
    logic [7:0] key_data_reg;
    logic       key_ready_reg;

    ps2_rx_frame #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk        (clk14),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_din    (ps2_din),
        .code       (code),
        .code_valid (code_valid),
        .frame_err  (frame_err)
    );

    // Ctrl folds the 40..5F column onto control codes 00..1F.
    assign ascii_raw = ps2_to_ascii(code, shift_reg);
    assign ascii     = (ctrl_reg && ascii_raw[6:5] == 2'b10) ? {2'b00, ascii_raw[4:0]} : ascii_raw;

    always_comb begin
        brk_next   = brk_reg;
        ext_next   = ext_reg;
        shift_next = shift_reg;
        ctrl_next  = ctrl_reg;
        new_key    = 1'b0;
        if (code_valid) begin
            if (code == SC_BRK) begin
                brk_next = 1'b1;
            end else if (code == SC_EXT) begin
                ext_next = 1'b1;
            end else begin
                brk_next = 1'b0;
                ext_next = 1'b0;
                if (code == SC_CTRL) begin
                    ctrl_next = !brk_reg;
                end else if (!ext_reg) begin
                    if (code == SC_LSHIFT || code == SC_RSHIFT)
                        shift_next = !brk_reg;
                    else if (!brk_reg && ascii_raw != 7'h00)
                        new_key = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk14 or negedge rst_n) begin
        if (!rst_n) begin
            brk_reg       <= 1'b0;
            ext_reg       <= 1'b0;
            shift_reg     <= 1'b0;
            ctrl_reg      <= 1'b0;
            key_data_reg  <= 8'h00;
            key_ready_reg <= 1'b0;
        end else begin
            brk_reg   <= brk_next;
            ext_reg   <= ext_next;
            shift_reg <= shift_next;
            ctrl_reg  <= ctrl_next;
            // A freshly latched key beats a simultaneous PIA read.
            if (new_key) begin
                key_data_reg  <= {1'b1, ascii};
                key_ready_reg <= 1'b1;
            end else if (kbd_rd) begin
                key_ready_reg <= 1'b0;
            end
        end
    end

    assign key_data  = key_data_reg;
    assign key_ready = key_ready_reg;

`ifdef APPLE1_KBD_HOTKEYS_EN
    logic reset_key_reg;
    logic cls_key_reg;
    logic hot_plain;

    // Hotkeys are plain (non-E0) codes; the ASCII table leaves F1/F12 unmapped, so no key results.
    assign hot_plain = code_valid && !ext_reg;

    always_ff @(posedge clk14 or negedge rst_n) begin
        if (!rst_n) begin
            reset_key_reg <= 1'b0;
            cls_key_reg   <= 1'b0;
        end else begin
            if (hot_plain && code == SC_F12)
                reset_key_reg <= !brk_reg;
            cls_key_reg <= hot_plain && !brk_reg && code == SC_F1;
        end
    end

    assign reset_key = reset_key_reg;
    assign cls_key   = cls_key_reg;
`else
    assign reset_key = 1'b0;
    assign cls_key   = 1'b0;
`endif

endmodule

// File: tb/tb_apple1_ps2_kbd.sv
// Directed bench for apple1_ps2_kbd: bit-banged PS/2 frames with hand-computed key values.
`timescale 1ns/1ps
module tb_apple1_ps2_kbd;

    localparam int HALF = 20;
`ifdef APPLE1_KBD_HOTKEYS_EN
    localparam logic HOT = 1'b1;
`else
    localparam logic HOT = 1'b0;
`endif

    logic       clk14   = 1'b0;
    logic       rst_n   = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_din = 1'b1;
    logic       kbd_rd  = 1'b0;
    logic [7:0] key_data;
    logic       key_ready;
    logic       frame_err;
    logic       reset_key;
    logic       cls_key;

    int         total  = 0;
    int         passed = 0;
    logic [7:0] err_cnt    = 8'd0;
    logic [7:0] cls_cycles = 8'd0;
    logic [7:0] e0;
    logic [7:0] c0;
    logic [7:0] exp_cls;

    apple1_ps2_kbd dut (
        .clk14     (clk14),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_din   (ps2_din),
        .kbd_rd    (kbd_rd),
        .key_data  (key_data),
        .key_ready (key_ready),
        .frame_err (frame_err),
        .reset_key (reset_key),
        .cls_key   (cls_key)
    );

    always #35 clk14 = ~clk14;

    always @(negedge clk14) begin
        if (frame_err) err_cnt = err_cnt + 8'd1;
        if (cls_key) cls_cycles = cls_cycles + 8'd1;
    end

    task automatic check_v(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk14);
    endtask

    // Drives the first nbits of an 11-bit frame; bad_par inverts the odd parity bit.
    task automatic send_bits(input logic [7:0] code, input logic bad_par, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^code) ^ bad_par, code, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_din = fr[i];
            wait_clk(HALF);
            ps2_clk = 1'b0;
            wait_clk(HALF);
            ps2_clk = 1'b1;
        end
        ps2_din = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code);
        send_bits(code, 1'b0, 11);
        wait_clk(HALF);
        $display("frame %02h -> key_data=%02h key_ready=%b reset_key=%b", code, key_data, key_ready, reset_key);
    endtask

    task automatic pulse_rd();
        kbd_rd = 1'b1;
        @(negedge clk14);
        kbd_rd = 1'b0;
        @(negedge clk14);
        $display("kbd_rd -> key_data=%02h key_ready=%b", key_data, key_ready);
    endtask

    // Sends a frame and raises kbd_rd in exactly the cycle its code_valid is seen.
    task automatic send_with_rd(input logic [7:0] code);
        fork
            send_bits(code, 1'b0, 11);
            begin
                int n;
                n = 0;
                while (dut.u_rx.code_valid !== 1'b1 && n < 2000) begin
                    @(negedge clk14);
                    n++;
                end
                if (n >= 2000) begin
                    total++;
                    $error("FAIL rd_align: observed no code_valid expected one within 2000 cycles");
                end else begin
                    kbd_rd = 1'b1;
                    @(negedge clk14);
                    kbd_rd = 1'b0;
                end
            end
        join
        wait_clk(HALF);
        $display("frame %02h with kbd_rd -> key_data=%02h key_ready=%b", code, key_data, key_ready);
    endtask

    initial begin
        wait_clk(5);
        check_v("rst_key_data", key_data, 8'h00);
        check_b("rst_key_ready", key_ready, 1'b0);
        check_b("rst_frame_err", frame_err, 1'b0);
        check_b("rst_reset_key", reset_key, 1'b0);
        check_b("rst_cls_key", cls_key, 1'b0);
        rst_n = 1'b1;
        wait_clk(10);

        // Plain letter and PIA read
        send_frame(8'h1C);
        check_v("a_key_data", key_data, 8'hC1);
        check_b("a_key_ready", key_ready, 1'b1);
        pulse_rd();
        check_b("a_rd_ready", key_ready, 1'b0);
        check_v("a_rd_data", key_data, 8'hC1);

        // Shift + 1, then break codes
        send_frame(8'h12);
        check_b("shift_no_key", key_ready, 1'b0);
        send_frame(8'h16);
        check_v("bang_data", key_data, 8'hA1);
        check_b("bang_ready", key_ready, 1'b1);
        pulse_rd();
        send_frame(8'hF0);
        send_frame(8'h16);
        send_frame(8'hF0);
        send_frame(8'h12);
        check_b("break_no_key", key_ready, 1'b0);
        check_v("break_data_hold", key_data, 8'hA1);
        send_frame(8'h16);
        check_v("one_unshifted", key_data, 8'hB1);
        pulse_rd();

        // Parity error, then timeout of a partial frame
        e0 = err_cnt;
        send_bits(8'h1C, 1'b1, 11);
        wait_clk(HALF);
        $display("bad-parity frame 1C -> frame_err pulses=%0d", err_cnt - e0);
        check_v("parity_err", err_cnt, e0 + 8'd1);
        check_b("parity_no_key", key_ready, 1'b0);
        send_bits(8'h1C, 1'b0, 10);
        wait_clk(20000);
        check_v("timeout_not_yet", err_cnt, e0 + 8'd1);
        wait_clk(23000);
        $display("partial frame + 3 ms idle -> frame_err pulses=%0d", err_cnt - e0);
        check_v("timeout_err", err_cnt, e0 + 8'd2);
        check_b("timeout_no_key", key_ready, 1'b0);
        send_frame(8'h5A);
        check_v("enter_data", key_data, 8'h8D);
        check_b("enter_ready", key_ready, 1'b1);
        pulse_rd();

        // Ctrl+C, then new key colliding with a PIA read
        send_frame(8'h14);
        send_frame(8'h21);
        check_v("ctrl_c_data", key_data, 8'h83);
        check_b("ctrl_c_ready", key_ready, 1'b1);
        send_with_rd(8'h1C);
        check_b("collide_ready", key_ready, 1'b1);
        check_v("collide_data", key_data, 8'h81);
        pulse_rd();
        send_frame(8'hF0);
        send_frame(8'h14);
        send_frame(8'h21);
        check_v("c_after_ctrl", key_data, 8'hC3);
        pulse_rd();

        // Extended code ignored; rubout and escape
        send_frame(8'hE0);
        send_frame(8'h75);
        check_b("ext_no_key", key_ready, 1'b0);
        send_frame(8'h66);
        check_v("rubout_data", key_data, 8'hDF);
        pulse_rd();
        send_frame(8'h76);
        check_v("esc_data", key_data, 8'h9B);
        pulse_rd();

        // Hotkeys
        send_frame(8'h07);
        check_b("f12_reset_key", reset_key, HOT);
        check_b("f12_no_key", key_ready, 1'b0);
        send_frame(8'hF0);
        send_frame(8'h07);
        check_b("f12_release", reset_key, 1'b0);
        c0 = cls_cycles;
        exp_cls = HOT ? 8'd1 : 8'd0;
        send_frame(8'h05);
        check_v("f1_cls_cycles", cls_cycles - c0, exp_cls);
        check_b("f1_no_key", key_ready, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
